// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
// Shared definitions for the UART framing bridge: header byte, FSM state
// encoding, payload/frame byte counts and the response byte selector.
// Build option: CHECKSUM_EN adds a trailing XOR checksum byte to command
// and response frames (frames grow from 5 to 6 bytes).
package uart_frame_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         PAYLOAD_BYTES  = 4;

`ifdef CHECKSUM_EN
  localparam int FRAME_BYTES = 6;
`else
  localparam int FRAME_BYTES = 5;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_PAYLOAD,
    ST_RX_CHK,
    ST_CALC,
    ST_TX_LOAD,
    ST_TX_WAIT
  } state_t;

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  // Byte idx of a response frame: header, result MSB first, checksum.
  function automatic logic [7:0] resp_byte(input logic [2:0]  idx,
                                           input logic [31:0] res,
                                           input logic [7:0]  hdr);
    logic [7:0] b;
    case (idx)
      3'd0:    b = hdr;
      3'd1:    b = res[31:24];
      3'd2:    b = res[23:16];
      3'd3:    b = res[15:8];
      3'd4:    b = res[7:0];
      3'd5:    b = xor_bytes(res);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_frame_bridge_timer.sv
// frame_timer
// Inter-byte timeout counter. Loads TIMEOUT_CYCLES-1 on reload, counts down
// while run is high and is held at zero while run is low. expired is high
// for the one cycle the count sits at zero while running; a reload in that
// same cycle suppresses it so an arriving byte always wins over expiry.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   run     in  count enable (frame reception in progress)
//   reload  in  restart the interval (a byte arrived)
//   expired out timeout indication, consumed on the next edge
module frame_timer import uart_frame_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic reload,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= LOAD;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = run && !reload && (cnt == '0);

endmodule

// File: rtl/uart_frame_bridge.sv
// uart_frame_bridge
// Assembles a host command frame (header + 4 operand bytes MSB first
// [+ XOR checksum]) into a 32-bit operand, launches the CORDIC core, then
// returns the 32-bit result as a response frame through the UART TX
// handshake. Build option: CHECKSUM_EN (see uart_frame_pkg).
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   RX_DATA, RX_DONE    received byte and its one-cycle strobe
//   TX_DATA, TX_START   byte to send and its one-cycle request
//   TX_DONE             transmitter finished the current byte
//   OP_DATA, OP_START   operand and start pulse to the core
//   RES_DATA, RES_DONE  core result and its valid pulse
//   FRAME_ERR           pulse on checksum failure or inter-byte timeout
module uart_frame_bridge import uart_frame_pkg::*; #(
  parameter logic [7:0] HEADER         = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_DONE,
  output logic [7:0]  TX_DATA,
  output logic        TX_START,
  input  logic        TX_DONE,
  output logic [31:0] OP_DATA,
  output logic        OP_START,
  input  logic [31:0] RES_DATA,
  input  logic        RES_DONE,
  output logic        FRAME_ERR
);

  state_t      state, state_n;
  logic [2:0]  byte_cnt, byte_cnt_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [31:0] op_data, op_data_n;
  logic [31:0] res_data, res_data_n;
  logic [7:0]  chk, chk_n;
  logic [7:0]  tx_data, tx_data_n;
  logic        op_start, op_start_n;
  logic        tx_start, tx_start_n;
  logic        frame_err, frame_err_n;

  logic timer_run;
  logic timeout;

  assign timer_run = (state == ST_RX_PAYLOAD) || (state == ST_RX_CHK);

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .run    (timer_run),
    .reload (RX_DONE),
    .expired(timeout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      tx_idx    <= '0;
      op_data   <= '0;
      res_data  <= '0;
      chk       <= '0;
      tx_data   <= '0;
      op_start  <= 1'b0;
      tx_start  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      tx_idx    <= tx_idx_n;
      op_data   <= op_data_n;
      res_data  <= res_data_n;
      chk       <= chk_n;
      tx_data   <= tx_data_n;
      op_start  <= op_start_n;
      tx_start  <= tx_start_n;
      frame_err <= frame_err_n;
    end
  end

  // Strobes are registered so each output pulse lands exactly one cycle
  // after the event that caused it and lasts a single cycle.
  always_comb begin
    state_n     = state;
    byte_cnt_n  = byte_cnt;
    tx_idx_n    = tx_idx;
    op_data_n   = op_data;
    res_data_n  = res_data;
    chk_n       = chk;
    tx_data_n   = tx_data;
    op_start_n  = 1'b0;
    tx_start_n  = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      ST_IDLE: begin
        if (RX_DONE && (RX_DATA == HEADER)) begin
          state_n    = ST_RX_PAYLOAD;
          byte_cnt_n = '0;
          chk_n      = '0;
        end
      end

      ST_RX_PAYLOAD: begin
        if (RX_DONE) begin
          op_data_n  = {op_data[23:0], RX_DATA};
          chk_n      = chk ^ RX_DATA;
          byte_cnt_n = byte_cnt + 3'd1;
          if (byte_cnt == 3'(PAYLOAD_BYTES - 1)) begin
            byte_cnt_n = '0;
`ifdef CHECKSUM_EN
            state_n    = ST_RX_CHK;
`else
            state_n    = ST_CALC;
            op_start_n = 1'b1;
`endif
          end
        end else if (timeout) begin
          frame_err_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end

      ST_RX_CHK: begin
        if (RX_DONE) begin
          if (RX_DATA == chk) begin
            state_n    = ST_CALC;
            op_start_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
            state_n     = ST_IDLE;
          end
        end else if (timeout) begin
          frame_err_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end

      ST_CALC: begin
        if (RES_DONE) begin
          res_data_n = RES_DATA;
          tx_idx_n   = '0;
          tx_data_n  = HEADER;
          tx_start_n = 1'b1;
          state_n    = ST_TX_LOAD;
        end
      end

      ST_TX_LOAD: begin
        state_n = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        if (TX_DONE) begin
          if (tx_idx == 3'(FRAME_BYTES - 1)) begin
            state_n = ST_IDLE;
          end else begin
            tx_idx_n   = tx_idx + 3'd1;
            tx_data_n  = resp_byte(tx_idx + 3'd1, res_data, HEADER);
            tx_start_n = 1'b1;
            state_n    = ST_TX_LOAD;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign TX_DATA   = tx_data;
  assign TX_START  = tx_start;
  assign OP_DATA   = op_data;
  assign OP_START  = op_start;
  assign FRAME_ERR = frame_err;

endmodule

// File: tb/tb_uart_frame_bridge.sv
module tb_uart_frame_bridge;

  localparam int TMO = 100;
`ifdef CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_DATA;
  logic        RX_DONE;
  logic [7:0]  TX_DATA;
  logic        TX_START;
  logic        TX_DONE;
  logic [31:0] OP_DATA;
  logic        OP_START;
  logic [31:0] RES_DATA;
  logic        RES_DONE;
  logic        FRAME_ERR;

  int checks   = 0;
  int failures = 0;
  int op_mon   = 0;
  int tx_mon   = 0;
  int err_mon  = 0;

  logic [31:0] exp_op[$];
  logic [7:0]  exp_tx[$];

  uart_frame_bridge #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_DATA  (RX_DATA),
    .RX_DONE  (RX_DONE),
    .TX_DATA  (TX_DATA),
    .TX_START (TX_START),
    .TX_DONE  (TX_DONE),
    .OP_DATA  (OP_DATA),
    .OP_START (OP_START),
    .RES_DATA (RES_DATA),
    .RES_DONE (RES_DONE),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every OP_START / TX_START pulse must match the next
  // queued expectation.
  always @(negedge CLK) begin
    if (FRAME_ERR === 1'b1) err_mon++;
    if (OP_START === 1'b1) begin
      op_mon++;
      checks++;
      assert (exp_op.size() > 0) else begin
        failures++;
        $error("FAIL op_unexpected observed=%h expected=none", OP_DATA);
      end
      if (exp_op.size() > 0) check("op_sb", OP_DATA, exp_op.pop_front());
    end
    if (TX_START === 1'b1) begin
      tx_mon++;
      checks++;
      assert (exp_tx.size() > 0) else begin
        failures++;
        $error("FAIL tx_unexpected observed=%h expected=none", TX_DATA);
      end
      if (exp_tx.size() > 0) check("tx_sb", {24'h0, TX_DATA}, {24'h0, exp_tx.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA = b;
    RX_DONE = 1'b1;
    tick(1);
    RX_DONE = 1'b0;
  endtask

  // Returns right after the edge that sampled the last byte.
  task automatic send_cmd(input logic [31:0] op);
    send_byte(8'hA5);
    for (int i = 3; i >= 0; i--) begin
      tick(2);
      send_byte(op[8*i +: 8]);
    end
`ifdef CHECKSUM_EN
    tick(2);
    send_byte(xor4(op));
`endif
  endtask

  task automatic push_resp(input logic [31:0] res);
    exp_tx.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(res[8*i +: 8]);
`ifdef CHECKSUM_EN
    exp_tx.push_back(xor4(res));
`endif
  endtask

  task automatic give_result(input logic [31:0] res);
    RES_DATA = res;
    RES_DONE = 1'b1;
    tick(1);
    RES_DONE = 1'b0;
    check("tx_start_after_res", {31'h0, TX_START}, 32'h1);
  endtask

  // Acknowledge n bytes; after each TX_DONE the next TX_START is due one
  // cycle later unless the frame of 'total' bytes is complete.
  task automatic serve_tx(input int n, input bit inject, input int total);
    for (int i = 0; i < n; i++) begin
      tick(3);
      if (inject) begin
        send_byte(8'hA5);
        tick(1);
      end
      check("tx_start_held_low", {31'h0, TX_START}, 32'h0);
      TX_DONE = 1'b1;
      tick(1);
      TX_DONE = 1'b0;
      if (i < total - 1) check("tx_start_after_done", {31'h0, TX_START}, 32'h1);
      else               check("tx_end_no_start", {31'h0, TX_START}, 32'h0);
    end
  endtask

  initial begin
    int seen;
    int err0;
    int snap;
    RST      = 1'b1;
    RX_DATA  = 8'h00;
    RX_DONE  = 1'b0;
    TX_DONE  = 1'b0;
    RES_DATA = 32'h0;
    RES_DONE = 1'b0;
    tick(3);
    check("rst_tx_start", {31'h0, TX_START}, 32'h0);
    check("rst_op_start", {31'h0, OP_START}, 32'h0);
    check("rst_frame_err", {31'h0, FRAME_ERR}, 32'h0);
    check("rst_tx_data", {24'h0, TX_DATA}, 32'h0);
    check("rst_op_data", OP_DATA, 32'h0);
    RST = 1'b0;
    tick(2);

    // Basic frame, zero result.
    exp_op.push_back(32'h3F800000);
    send_cmd(32'h3F800000);
    check("op_start_lat1", {31'h0, OP_START}, 32'h1);
    check("op_data1", OP_DATA, 32'h3F800000);
    tick(3);
    push_resp(32'h00000000);
    give_result(32'h00000000);
    serve_tx(NBYTES, 1'b0, NBYTES);

    // Stray RES_DONE while idle must not produce a response.
    snap = tx_mon;
    give_result_idle: begin
      RES_DATA = 32'h11111111;
      RES_DONE = 1'b1;
      tick(1);
      RES_DONE = 1'b0;
      tick(3);
    end
    check("res_done_idle_ignored", tx_mon, snap);

`ifdef CHECKSUM_EN
    // Bad checksum: error pulse, no operand launch.
    err0 = err_mon;
    send_byte(8'hA5);
    for (int i = 1; i <= 4; i++) begin
      tick(2);
      send_byte(8'(i));
    end
    tick(2);
    send_byte(8'hFF);
    check("chk_bad_err", {31'h0, FRAME_ERR}, 32'h1);
    check("chk_bad_no_op", {31'h0, OP_START}, 32'h0);
    tick(2);
    check("chk_bad_err_cnt", err_mon, err0 + 1);
`endif

    // Junk byte before header, extra bytes during CALC and TX_WAIT.
    send_byte(8'h12);
    tick(2);
    exp_op.push_back(32'h01020304);
    send_cmd(32'h01020304);
    check("op_start_lat2", {31'h0, OP_START}, 32'h1);
    check("op_data2", OP_DATA, 32'h01020304);
    tick(1);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      send_byte(8'h11 * 8'(i + 1));
    end
    tick(2);
    check("op_data_calc_hold", OP_DATA, 32'h01020304);
    push_resp(32'hDEADBEEF);
    give_result(32'hDEADBEEF);
    serve_tx(NBYTES, 1'b1, NBYTES);
    check("op_data_after_tx", OP_DATA, 32'h01020304);
    tick(2);

    // Inter-byte timeout, then recovery with a valid frame.
    err0 = err_mon;
    snap = op_mon;
    send_byte(8'hA5);
    tick(2);
    send_byte(8'h01);
    seen = 0;
    for (int k = 1; k <= 3 * TMO; k++) begin
      tick(1);
      if (FRAME_ERR === 1'b1) begin
        seen = k;
        break;
      end
    end
    check("timeout_window", {31'h0, (seen >= TMO - 1) && (seen <= TMO + 1)}, 32'h1);
    tick(2);
    check("timeout_err_cnt", err_mon, err0 + 1);
    check("timeout_no_op", op_mon, snap);
    exp_op.push_back(32'h0A0B0C0D);
    send_cmd(32'h0A0B0C0D);
    check("op_after_timeout", {31'h0, OP_START}, 32'h1);
    tick(2);
    push_resp(32'h12345678);
    give_result(32'h12345678);
    serve_tx(NBYTES, 1'b0, NBYTES);
    tick(2);

    // Reset while waiting on the second response byte.
    exp_op.push_back(32'hCAFEBABE);
    send_cmd(32'hCAFEBABE);
    check("op_start_lat3", {31'h0, OP_START}, 32'h1);
    tick(2);
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h87);
    give_result(32'h87654321);
    serve_tx(1, 1'b0, NBYTES);
    tick(2);
    RST = 1'b1;
    tick(1);
    check("mid_rst_tx_start", {31'h0, TX_START}, 32'h0);
    check("mid_rst_op_start", {31'h0, OP_START}, 32'h0);
    check("mid_rst_frame_err", {31'h0, FRAME_ERR}, 32'h0);
    check("mid_rst_tx_data", {24'h0, TX_DATA}, 32'h0);
    check("mid_rst_op_data", OP_DATA, 32'h0);
    RST = 1'b0;
    snap = tx_mon;
    tick(2);
    TX_DONE = 1'b1;
    tick(1);
    TX_DONE = 1'b0;
    tick(20);
    check("no_tx_after_rst", tx_mon, snap);

    // Normal operation after reset.
    exp_op.push_back(32'h40490FDB);
    send_cmd(32'h40490FDB);
    check("op_after_rst", {31'h0, OP_START}, 32'h1);
    tick(2);
    push_resp(32'h3F317218);
    give_result(32'h3F317218);
    serve_tx(NBYTES, 1'b0, NBYTES);
    tick(4);

    check("exp_op_drained", exp_op.size(), 0);
    check("exp_tx_drained", exp_tx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_bridge.md
# uart_frame_bridge

Framing engine between the UART byte interface and the CORDIC natural-log core. It assembles a host command frame from received UART bytes into a 32-bit operand and launches the core. It then serializes the 32-bit result back to the host as a response frame through the UART transmitter handshake. This block is the protocol end that consumes RX_DATA/RX_DONE and drives TX_START/TX_DATA.

## Interface
- HEADER, 8'hA5, sync byte that opens every command and response frame
- TIMEOUT_CYCLES, 1_000_000, max CLK cycles between bytes of one command frame
- CLK  in  1  system clock; single clock domain
- RST  in  1  reset, synchronous, active-high
- RX_DATA  in  8  received byte, valid when RX_DONE=1
- RX_DONE  in  1  one-cycle pulse per received byte
- TX_DATA  out  8  byte to transmit
- TX_START  out  1  one-cycle pulse requesting transmission of TX_DATA
- TX_DONE  in  1  one-cycle pulse when the transmitter finishes a byte
- OP_DATA  out  32  operand to the CORDIC core
- OP_START  out  1  one-cycle operand-valid/start pulse
- RES_DATA  in  32  result from the core, valid when RES_DONE=1
- RES_DONE  in  1  one-cycle result-valid pulse
- FRAME_ERR  out  1  one-cycle pulse on checksum failure or inter-byte timeout

## Operation
- Command frame: HEADER, then operand bytes MSB first (b3, b2, b1, b0), then an optional checksum (see Configuration).
- Response frame: HEADER, then result bytes MSB first, then an optional checksum.
- States: IDLE, RX_PAYLOAD, RX_CHK, CALC, TX_LOAD, TX_WAIT.
- IDLE: on RX_DONE with RX_DATA==HEADER, go to RX_PAYLOAD and clear the byte count. Any other byte is silently discarded.
- RX_PAYLOAD: each RX_DONE shifts RX_DATA into the operand register (shift left 8). After the 4th byte, go to RX_CHK if CHECKSUM_EN, else to CALC.
- RX_CHK: on RX_DONE, compare against the XOR of the 4 payload bytes.
  - Match: go to CALC.
  - Mismatch: pulse FRAME_ERR and return to IDLE without OP_START.
- CALC: OP_START pulses on the first cycle in CALC, with OP_DATA stable from then until the next frame. On RES_DONE, capture RES_DATA and go to TX_LOAD.
- TX_LOAD: drive the next response byte on TX_DATA and pulse TX_START; go to TX_WAIT.
- TX_WAIT: TX_DATA is held. On TX_DONE, go to TX_LOAD if bytes remain, else IDLE.
- RX_DONE in CALC, TX_LOAD or TX_WAIT is ignored; no queuing.
- RES_DONE outside CALC is ignored.

## Timing
- Reset values: TX_START=0, OP_START=0, FRAME_ERR=0, TX_DATA=8'h00, OP_DATA=32'h0. State is IDLE and all counters are 0.
- OP_START is asserted one cycle after the RX_DONE of the last command byte.
- First TX_START is asserted one cycle after RES_DONE. Each subsequent TX_START is asserted one cycle after the previous TX_DONE.
- Timeout counter:
  - Runs only in RX_PAYLOAD and RX_CHK, and reloads on every RX_DONE.
  - On reaching TIMEOUT_CYCLES it pulses FRAME_ERR and returns to IDLE.
  - If RX_DONE coincides with expiry, the byte wins and the counter reloads.
- Simultaneous TX_DONE and RES_DONE cannot matter: they are accepted only in their own states.
- RST asserted mid-frame or mid-transmission returns to reset values on the next edge. The partial frame is lost and no further TX_START is issued.

## Configuration
- CHECKSUM_EN defined:
  - Command frames carry a 6th byte: XOR of the 4 operand bytes. It is verified in RX_CHK.
  - Response frames carry a 6th byte: XOR of the 4 result bytes.
- CHECKSUM_EN undefined:
  - Frames are 5 bytes and RX_CHK is unreachable.
  - FRAME_ERR is raised only by timeout.

## Structure
- Package uart_frame_pkg holds the HEADER default, the state enum, the payload byte count (4), and the frame lengths (5/6) selected by CHECKSUM_EN.
- One sub-module, frame_timer: loadable down-counter with a reload input and an expiry pulse, parameterized by TIMEOUT_CYCLES.

## Test plan
- Send A5 3F 80 00 00 (plus checksum BF with CHECKSUM_EN). Expect one OP_START with OP_DATA=32'h3F800000. Return RES_DATA=32'h00000000. Expect TX bytes A5 00 00 00 00 (plus 00), each byte waiting for TX_DONE.
- Send 12 A5 01 02 03 04. Expect byte 12 discarded and OP_DATA=32'h01020304.
- With CHECKSUM_EN, send A5 01 02 03 04 FF. Expect FRAME_ERR pulse, no OP_START, and state back in IDLE.
- With TIMEOUT_CYCLES=100, send A5 01 then stall 100 cycles. Expect FRAME_ERR. Then send a full valid frame and expect it to be accepted normally.
- Send extra bytes during CALC and during TX_WAIT. Expect them ignored and the response frame unchanged.
- Assert RST during TX_WAIT after the 2nd response byte. Expect all outputs at reset values and no further TX_START.
